// File: rtl/scan_decoder_pkg.sv
// Shared types and the one-hot helper for the scan_decoder block.
// Width-independent so both RTL and models can reuse onehot().
package scan_decoder_pkg;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    typedef enum logic {MODE_DIRECT, MODE_SCAN} mode_t;

    localparam int MAX_SEL_WIDTH = 8;
    localparam int MAX_OUT_COUNT = 2 ** MAX_SEL_WIDTH;

    function automatic logic [MAX_OUT_COUNT-1:0] onehot(input logic [MAX_SEL_WIDTH-1:0] code);
        onehot       = '0;
        onehot[code] = 1'b1;
    endfunction

endpackage

// File: rtl/scan_decoder_dwell_timer.sv
// Dwell timer: counts clocks while run is high and pulses expire on the last
// clock of each DWELL_CYCLES-long window; clear restarts the window.
module scan_decoder_dwell_timer #(
    parameter int DWELL_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expire = run && !clear && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= expire ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered N:2^N one-hot decoder with handshaked DIRECT mode and self-sequencing SCAN mode.
// Optional SCAN_DECODER_TRISTATE_EN: Data_Out floats to 'z while idle (reset still drives 0).
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_WIDTH    = 4,
    parameter int DWELL_CYCLES = 16,
    localparam int OUT_COUNT   = 2 ** SEL_WIDTH
) (
    input  logic                 Clk_In,
    input  logic                 Reset_n_In,
    input  logic                 Enable_In,
    input  logic                 Mode_In,
    input  logic                 Valid_In,
    output logic                 Ready_Out,
    input  logic [SEL_WIDTH-1:0] Encoded_Value_In,
    input  logic [SEL_WIDTH-1:0] Scan_Limit_In,
    output logic [OUT_COUNT-1:0] Data_Out,
    output logic [SEL_WIDTH-1:0] Index_Out,
    output logic                 Valid_Out,
    output logic                 Scan_Wrap_Out
);

    state_t               state;
    logic [OUT_COUNT-1:0] data_q;
    logic [SEL_WIDTH-1:0] next_idx;
    logic                 in_scan, not_scan, go_scan, go_direct, expire;

    assign in_scan   = (state == SCAN);
    assign not_scan  = !in_scan;
    assign go_scan   = Enable_In && (mode_t'(Mode_In) == MODE_SCAN);
    assign go_direct = Enable_In && (mode_t'(Mode_In) == MODE_DIRECT);
    assign next_idx  = Index_Out + 1'b1;

    scan_decoder_dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk   (Clk_In),
        .rst_n (Reset_n_In),
        .clear (not_scan),
        .run   (in_scan),
        .expire(expire)
    );

`ifdef SCAN_DECODER_TRISTATE_EN
    logic hiz_q;
    assign Data_Out = hiz_q ? {OUT_COUNT{1'bz}} : data_q;
`else
    assign Data_Out = data_q;
`endif

    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state         <= IDLE;
            data_q        <= '0;
            Index_Out     <= '0;
            Valid_Out     <= 1'b0;
            Ready_Out     <= 1'b0;
            Scan_Wrap_Out <= 1'b0;
`ifdef SCAN_DECODER_TRISTATE_EN
            hiz_q         <= 1'b0;
`endif
        end else begin
            Scan_Wrap_Out <= 1'b0;
`ifdef SCAN_DECODER_TRISTATE_EN
            hiz_q         <= !Enable_In;
`endif
            if (go_scan) begin
                state     <= SCAN;
                Ready_Out <= 1'b0;
                Valid_Out <= 1'b1;
                if (!in_scan) begin
                    Index_Out <= '0;
                    data_q    <= OUT_COUNT'(onehot('0));
                end else if (expire) begin
                    // >= also catches a limit lowered below the current index
                    if (Index_Out >= Scan_Limit_In) begin
                        Index_Out     <= '0;
                        data_q        <= OUT_COUNT'(onehot('0));
                        Scan_Wrap_Out <= 1'b1;
                    end else begin
                        Index_Out <= next_idx;
                        data_q    <= OUT_COUNT'(onehot(MAX_SEL_WIDTH'(next_idx)));
                    end
                end
            end else if (go_direct) begin
                state     <= DIRECT;
                Ready_Out <= 1'b1;
                if ((state == DIRECT) && Valid_In && Ready_Out) begin
                    Index_Out <= Encoded_Value_In;
                    data_q    <= OUT_COUNT'(onehot(MAX_SEL_WIDTH'(Encoded_Value_In)));
                    Valid_Out <= 1'b1;
                end
            end else begin
                state     <= IDLE;
                Ready_Out <= 1'b0;
                Valid_Out <= 1'b0;
                data_q    <= '0;
            end
        end
    end

endmodule
